// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the buffered UART transmitter
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Data is zero-extended to 9 bits by the caller; padding zeros leave the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        case (mode)
            PARITY_ODD:  return ~^data;
            PARITY_EVEN: return ^data;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and overflow pulse
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Full is judged before any same-cycle pop, so a write at full is always dropped.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-fed UART transmitter sending back-to-back frames
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE   = 19_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int DEPTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_BITS-1:0]       wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       busy,
    output logic                       tx_done,
    output logic                       tx_out
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] DONE_AT   = CNT_W'(BAUD_DIV - 2);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    tx_state_t            state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par;
    logic [DATA_BITS-1:0] head;
    logic                 bit_end;
    logic                 frame_end;
    logic                 pop;

    assign bit_end   = (bit_cnt == BIT_LAST);
    assign frame_end = (state == STOP) && bit_end && (bit_idx == STOP_LAST);
    assign pop       = !empty && ((state == IDLE) || frame_end);

    sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            // Registered, so it is raised one cycle early to land on the frame's final cycle.
            tx_done <= (state == STOP) && (bit_idx == STOP_LAST) && (bit_cnt == DONE_AT);
            bit_cnt <= bit_end ? '0 : bit_cnt + CNT_W'(1);
            if (pop) begin
                state   <= START;
                shift   <= head;
                par     <= parity_bit(9'(head), PARITY_MODE);
                bit_cnt <= '0;
                bit_idx <= '0;
                tx_out  <= 1'b0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx_out  <= 1'b1;
                        busy    <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state  <= DATA;
                            tx_out <= shift[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_idx == DATA_LAST) begin
                                bit_idx <= '0;
                                if (PARITY_MODE != PARITY_NONE) begin
                                    state  <= PARITY;
                                    tx_out <= par;
                                end else begin
                                    state  <= STOP;
                                    tx_out <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                                shift   <= shift >> 1;
                                tx_out  <= shift[1];
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            if (bit_idx == STOP_LAST) begin
                                state   <= IDLE;
                                bit_idx <= '0;
                                busy    <= 1'b0;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                            tx_out <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        tx_out <= 1'b1;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - frame-level model check of three uart_tx_buffered configurations
module tb_uart_tx_buffered;

    localparam int BAUD = 10;
    localparam int DEP  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en [3];
    logic [7:0] wdat [3];
    logic       tx [3];
    logic       busy [3];
    logic       done [3];
    logic       ovf [3];
    logic       full [3];
    logic       empty [3];
    logic [2:0] cnt [3];

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                       .PARITY_MODE(1), .STOP_BITS(1), .DEPTH(DEP)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_data(wdat[0]),
        .full(full[0]), .empty(empty[0]), .count(cnt[0]), .overflow(ovf[0]),
        .busy(busy[0]), .tx_done(done[0]), .tx_out(tx[0]));

    uart_tx_buffered #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                       .PARITY_MODE(0), .STOP_BITS(2), .DEPTH(DEP)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_data(wdat[1][6:0]),
        .full(full[1]), .empty(empty[1]), .count(cnt[1]), .overflow(ovf[1]),
        .busy(busy[1]), .tx_done(done[1]), .tx_out(tx[1]));

    uart_tx_buffered #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                       .PARITY_MODE(2), .STOP_BITS(1), .DEPTH(DEP)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .wr_data(wdat[2]),
        .full(full[2]), .empty(empty[2]), .count(cnt[2]), .overflow(ovf[2]),
        .busy(busy[2]), .tx_done(done[2]), .tx_out(tx[2]));

    function automatic int cfg_db(input int i);
        return (i == 1) ? 7 : 8;
    endfunction

    function automatic int cfg_par(input int i);
        return (i == 0) ? 1 : ((i == 2) ? 2 : 0);
    endfunction

    function automatic int cfg_stop(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst %0d at %0t: actual %0d expected %0d", name, inst, $time, act, exp);
        end
    endtask

    // Model: a queue of characters and a position inside a list of per-bit line levels.
    int mfifo [3][DEP];
    int mhead [3];
    int mcnt [3];
    int fpos [3];
    int flen [3];
    int fbits [3][16];
    int movf [3];

    task automatic build_frame(input int i, input int d);
        int n = 0;
        int ones = 0;
        fbits[i][n++] = 0;
        for (int b = 0; b < cfg_db(i); b++) begin
            fbits[i][n++] = (d >> b) & 1;
            ones += (d >> b) & 1;
        end
        if (cfg_par(i) == 1) fbits[i][n++] = (ones % 2 == 0) ? 1 : 0;
        if (cfg_par(i) == 2) fbits[i][n++] = ones % 2;
        for (int s = 0; s < cfg_stop(i); s++) fbits[i][n++] = 1;
        flen[i] = n * BAUD;
    endtask

    task automatic model_step(input int i);
        int pre = mcnt[i];
        int tail = (mhead[i] + mcnt[i]) % DEP;
        bit pop = 0;
        movf[i] = (wr_en[i] && pre == DEP) ? 1 : 0;
        if (fpos[i] < 0) begin
            pop = (pre > 0);
        end else if (fpos[i] == flen[i] - 1) begin
            if (pre > 0) pop = 1;
            else fpos[i] = -1;
        end else begin
            fpos[i]++;
        end
        if (pop) begin
            build_frame(i, mfifo[i][mhead[i]]);
            mhead[i] = (mhead[i] + 1) % DEP;
            mcnt[i]--;
            fpos[i] = 0;
        end
        if (wr_en[i] && pre < DEP) begin
            mfifo[i][tail] = int'(wdat[i]) & ((1 << cfg_db(i)) - 1);
            mcnt[i]++;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mhead[i] = 0; mcnt[i] = 0; fpos[i] = -1; flen[i] = 0; movf[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) model_step(i);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 3; i++) begin
                chk("cmp_tx_out", i, tx[i], (fpos[i] < 0) ? 1 : fbits[i][fpos[i] / BAUD]);
                chk("cmp_busy", i, busy[i], (fpos[i] >= 0) ? 1 : 0);
                chk("cmp_tx_done", i, done[i], (fpos[i] >= 0 && fpos[i] == flen[i] - 1) ? 1 : 0);
                chk("cmp_overflow", i, ovf[i], movf[i]);
                chk("cmp_count", i, cnt[i], mcnt[i]);
                chk("cmp_empty", i, empty[i], (mcnt[i] == 0) ? 1 : 0);
                chk("cmp_full", i, full[i], (mcnt[i] == DEP) ? 1 : 0);
            end
        end
    end

    // Recorded per-cycle outputs of the instance under test; index c is sampled before the drive of cycle c.
    int rtx [600];
    int rbusy [600];
    int rdone [600];
    int rovf [600];
    int rcnt [600];
    int rfull [600];
    int rempty [600];
    int scyc [8];
    int sdat [8];
    int nsched;

    task automatic run(input int inst, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            rtx[c] = tx[inst]; rbusy[c] = busy[inst]; rdone[c] = done[inst];
            rovf[c] = ovf[inst]; rcnt[c] = cnt[inst]; rfull[c] = full[inst]; rempty[c] = empty[inst];
            wr_en[inst] = 1'b0;
            for (int s = 0; s < nsched; s++) begin
                if (scyc[s] == c) begin
                    wr_en[inst] = 1'b1;
                    wdat[inst] = 8'(sdat[s]);
                end
            end
        end
        wr_en[inst] = 1'b0;
        nsched = 0;
    endtask

    task automatic add(input int c, input int d);
        scyc[nsched] = c;
        sdat[nsched] = d;
        nsched++;
    endtask

    function automatic int sum_of(input int which, input int n);
        int s = 0;
        for (int c = 0; c < n; c++) begin
            case (which)
                0: s += rbusy[c];
                1: s += rdone[c];
                2: s += rovf[c];
                default: s += rtx[c];
            endcase
        end
        return s;
    endfunction

    int exp_a5 [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};

    initial begin
        for (int i = 0; i < 3; i++) begin
            wr_en[i] = 1'b0;
            wdat[i] = 8'h00;
        end
        nsched = 0;
        repeat (3) @(negedge clk);
        chk("rst_tx_out", 0, tx[0], 1);
        chk("rst_busy", 0, busy[0], 0);
        chk("rst_empty", 0, empty[0], 1);
        chk("rst_count", 0, cnt[0], 0);
        chk("rst_overflow", 0, ovf[0], 0);
        rst_n = 1'b1;
        cmp_on = 1;

        // single 0xA5 frame, odd parity
        add(0, 8'hA5);
        run(0, 115);
        chk("t1_empty_k1", 0, rempty[1], 0);
        chk("t1_idle_k1", 0, rtx[1], 1);
        chk("t1_busy_k1", 0, rbusy[1], 0);
        for (int b = 0; b < 11; b++) chk("t1_bit", b, rtx[2 + 10 * b + 5], exp_a5[b]);
        chk("t1_start_last", 0, rtx[11], 0);
        chk("t1_busy_cycles", 0, sum_of(0, 115), 110);
        chk("t1_busy_end", 0, rbusy[112], 0);
        chk("t1_done_count", 0, sum_of(1, 115), 1);
        chk("t1_done_at_109", 0, rdone[111], 1);

        // overflow into a depth-4 FIFO
        for (int c = 0; c < 6; c++) add(c, 8'h11 + c);
        run(0, 560);
        chk("t2_count_after4", 0, rcnt[4], 3);
        chk("t2_full_after5", 0, rfull[5], 1);
        chk("t2_overflow_pulse", 0, rovf[6], 1);
        chk("t2_overflow_count", 0, sum_of(2, 560), 1);
        chk("t2_busy_cycles", 0, sum_of(0, 560), 550);
        chk("t2_busy_last", 0, rbusy[551], 1);
        chk("t2_busy_end", 0, rbusy[552], 0);
        chk("t2_empty_end", 0, rempty[552], 1);
        chk("t2_done_count", 0, sum_of(1, 560), 5);

        // write on the same edge as the end-of-frame pop
        add(0, 8'h21); add(1, 8'h22); add(2, 8'h23); add(111, 8'h24);
        run(0, 450);
        chk("t6_count_before", 0, rcnt[111], 2);
        chk("t6_done_before", 0, rdone[111], 1);
        chk("t6_count_after", 0, rcnt[112], 2);
        chk("t6_no_overflow", 0, sum_of(2, 450), 0);
        chk("t6_next_start", 0, rtx[112], 0);
        chk("t6_busy_cycles", 0, sum_of(0, 450), 440);

        // 7 data bits, no parity, two stop bits
        add(0, 8'h7F);
        run(1, 105);
        chk("t3_busy_cycles", 1, sum_of(0, 105), 100);
        chk("t3_low_cycles", 1, 105 - sum_of(3, 105), 10);
        chk("t3_first_data", 1, rtx[12], 1);
        chk("t3_done", 1, rdone[101], 1);
        chk("t3_busy_end", 1, rbusy[102], 0);

        // even parity, contiguous frames
        add(0, 8'h01); add(1, 8'h03);
        run(2, 230);
        chk("t4_parity_01", 2, rtx[97], 1);
        chk("t4_parity_03", 2, rtx[207], 0);
        chk("t4_stop", 2, rtx[111], 1);
        chk("t4_start2", 2, rtx[112], 0);
        chk("t4_busy_cycles", 2, sum_of(0, 230), 220);

        // asynchronous reset mid-frame with two entries queued
        add(0, 8'h00); add(1, 8'h00); add(2, 8'h00);
        run(0, 52);
        @(negedge clk);
        chk("t5_pre_tx", 0, tx[0], 0);
        chk("t5_pre_count", 0, cnt[0], 2);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", 0, tx[0], 1);
        chk("t5_rst_busy", 0, busy[0], 0);
        chk("t5_rst_count", 0, cnt[0], 0);
        chk("t5_rst_empty", 0, empty[0], 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run(0, 40);
        chk("t5_idle_high", 0, sum_of(3, 40), 40);
        chk("t5_idle_busy", 0, sum_of(0, 40), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
